// File: rtl/flash_op_seq.sv
// Flash operation sequencer between the controller register front-end and
// the flash PHY. Accepts one read/program/page-erase/bank-erase operation at
// a time, range-checks it, then issues one PHY transaction per word (or one
// per erase) while streaming program data in and read data out.
// Optional build macro: FLASH_OP_SEQ_ABORT_EN adds op_abort_i, which ends a
// running operation early with an error.
module flash_op_seq #(
  parameter int Banks        = 2,
  parameter int PagesPerBank = 128,
  parameter int WordsPerPage = 256,
  parameter int BytesPerWord = 4,
  parameter int CntW         = 12,
  localparam int BkW  = (Banks > 1) ? $clog2(Banks) : 1,
  localparam int PgW  = $clog2(PagesPerBank),
  localparam int WdW  = $clog2(WordsPerPage),
  localparam int AW   = BkW + PgW + WdW,
  localparam int DW   = BytesPerWord * 8,
  localparam int BAW  = AW + $clog2(BytesPerWord)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            op_valid_i,
  output logic            op_ready_o,
  input  logic [1:0]      op_type_i,
  input  logic [BAW-1:0]  op_addr_i,
  input  logic [CntW-1:0] op_num_i,
`ifdef FLASH_OP_SEQ_ABORT_EN
  input  logic            op_abort_i,
`endif
  input  logic            wdata_valid_i,
  output logic            wdata_ready_o,
  input  logic [DW-1:0]   wdata_i,
  output logic            rdata_valid_o,
  input  logic            rdata_ready_i,
  output logic [DW-1:0]   rdata_o,
  output logic            phy_req_o,
  output logic [1:0]      phy_op_o,
  output logic [BkW-1:0]  phy_bank_o,
  output logic [PgW-1:0]  phy_page_o,
  output logic [WdW-1:0]  phy_word_o,
  output logic [DW-1:0]   phy_wdata_o,
  input  logic            phy_ack_i,
  input  logic [DW-1:0]   phy_rdata_i,
  output logic            op_done_o,
  output logic            op_err_o,
  output logic [CntW:0]   words_done_o
);

  localparam int OffW = $clog2(BytesPerWord);
  localparam int unsigned MaxWord = Banks * PagesPerBank * WordsPerPage - 1;
  localparam int SumW   = ((AW > CntW) ? AW : CntW) + 1;
  localparam int PgSumW = ((WdW > CntW) ? WdW : CntW) + 1;

  localparam logic [1:0] OpRead  = 2'd0;
  localparam logic [1:0] OpProg  = 2'd1;
  localparam logic [1:0] OpPgErs = 2'd2;
  localparam logic [1:0] OpBkErs = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    FETCH,
    ISSUE,
    RDHOLD,
    FINISH
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CntW-1:0] num_q, num_d;
  logic [CntW:0]   cnt_q, cnt_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            misalign_q, misalign_d;

  logic [SumW-1:0]   rd_sum;
  logic [PgSumW-1:0] pg_sum;
  logic              rd_oob, pg_oob, last_word;
  logic              abort_now, abort_issue;

`ifdef FLASH_OP_SEQ_ABORT_EN
  logic abort_pend_q, abort_pend_d;

  assign abort_now   = op_abort_i;
  assign abort_issue = abort_pend_q | op_abort_i;

  // Remember an abort raised while a PHY transaction is in flight until it is acknowledged.
  always_comb begin
    abort_pend_d = 1'b0;
    if (state_q == ISSUE && !phy_ack_i) begin
      abort_pend_d = abort_pend_q | op_abort_i;
    end
  end

  // Pending-abort register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      abort_pend_q <= 1'b0;
    end else begin
      abort_pend_q <= abort_pend_d;
    end
  end
`else
  assign abort_now   = 1'b0;
  assign abort_issue = 1'b0;
`endif

  // Range checks: reads must not run off the end of flash, programs must stay in one page.
  always_comb begin
    rd_sum    = SumW'(addr_q) + SumW'(num_q);
    pg_sum    = PgSumW'(addr_q[WdW-1:0]) + PgSumW'(num_q);
    rd_oob    = rd_sum > SumW'(MaxWord);
    pg_oob    = pg_sum > PgSumW'(WordsPerPage - 1);
    last_word = (cnt_q == {1'b0, num_q});
  end

  // Next-state and datapath updates for the operation sequencer.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    num_d      = num_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    misalign_d = misalign_q;
    unique case (state_q)
      IDLE: begin
        if (op_valid_i) begin
          op_d       = op_type_i;
          addr_d     = AW'(op_addr_i >> OffW);
          misalign_d = (op_addr_i & BAW'(BytesPerWord - 1)) != '0;
          num_d      = op_num_i;
          cnt_d      = '0;
          err_d      = 1'b0;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        if (misalign_q || (op_q == OpRead && rd_oob) || (op_q == OpProg && pg_oob)) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else if (op_q == OpProg) begin
          state_d = FETCH;
        end else begin
          state_d = ISSUE;
        end
      end
      FETCH: begin
        if (abort_now) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else if (wdata_valid_i) begin
          wdata_d = wdata_i;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (phy_ack_i) begin
          unique case (op_q)
            OpRead: begin
              if (abort_issue) begin
                err_d   = 1'b1;
                state_d = FINISH;
              end else begin
                rdata_d = phy_rdata_i;
                state_d = RDHOLD;
              end
            end
            OpProg: begin
              cnt_d = cnt_q + (CntW+1)'(1);
              if (last_word || abort_issue) begin
                err_d   = abort_issue;
                state_d = FINISH;
              end else begin
                addr_d  = addr_q + AW'(1);
                state_d = FETCH;
              end
            end
            default: begin
              err_d   = abort_issue;
              state_d = FINISH;
            end
          endcase
        end
      end
      RDHOLD: begin
        if (rdata_ready_i) begin
          cnt_d = cnt_q + (CntW+1)'(1);
          if (last_word || abort_now) begin
            err_d   = abort_now;
            state_d = FINISH;
          end else begin
            addr_d  = addr_q + AW'(1);
            state_d = ISSUE;
          end
        end else if (abort_now) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      op_q       <= 2'd0;
      addr_q     <= '0;
      num_q      <= '0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      num_q      <= num_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      misalign_q <= misalign_d;
    end
  end

  // PHY address decode; erases force the unused low fields to zero.
  always_comb begin
    phy_bank_o = addr_q[AW-1 -: BkW];
    phy_page_o = addr_q[WdW +: PgW];
    phy_word_o = addr_q[WdW-1:0];
    if (op_q == OpPgErs) begin
      phy_word_o = '0;
    end else if (op_q == OpBkErs) begin
      phy_page_o = '0;
      phy_word_o = '0;
    end
  end

  assign op_ready_o    = (state_q == IDLE);
  assign wdata_ready_o = (state_q == FETCH);
  assign phy_req_o     = (state_q == ISSUE);
  assign rdata_valid_o = (state_q == RDHOLD);
  assign op_done_o     = (state_q == FINISH);
  assign op_err_o      = (state_q == FINISH) && err_q;
  assign phy_op_o      = op_q;
  assign phy_wdata_o   = wdata_q;
  assign rdata_o       = rdata_q;
  assign words_done_o  = cnt_q;

endmodule
